// File: rtl/change_dispenser_ctrl_if.sv
// Bundles the checkout request, ejector handshake, refill strobe and status
// signals of the change dispenser. The master side is the controller.
interface change_dispenser_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             change_req;
   logic [7:0]       change_amt;
   logic             eject_ready;
   logic             refill_en;
   logic [1:0]       refill_sel;
   logic [CNT_W-1:0] refill_cnt;
   logic             busy;
   logic             eject_valid;
   logic [7:0]       eject_coin;
   logic             done;
   logic [7:0]       short_amt;
   logic [CNT_W-1:0] tube_cnt_50;
   logic [CNT_W-1:0] tube_cnt_10;
   logic [CNT_W-1:0] tube_cnt_5;
   logic [CNT_W-1:0] tube_cnt_1;

   modport master (
      input  change_req, change_amt, eject_ready, refill_en, refill_sel, refill_cnt,
      output busy, eject_valid, eject_coin, done, short_amt,
      output tube_cnt_50, tube_cnt_10, tube_cnt_5, tube_cnt_1
   );

   modport slave (
      output change_req, change_amt, eject_ready, refill_en, refill_sel, refill_cnt,
      input  busy, eject_valid, eject_coin, done, short_amt,
      input  tube_cnt_50, tube_cnt_10, tube_cnt_5, tube_cnt_1
   );
endinterface

// File: rtl/change_dispenser_ctrl.sv
// Greedy 50/10/5/1 change dispenser: decomposes the owed amount against the
// tube inventory and issues one coin at a time to the ejector.
module change_dispenser_ctrl #(
   parameter int CNT_W   = 8,
   parameter int INIT_50 = 4,
   parameter int INIT_10 = 10,
   parameter int INIT_5  = 10,
   parameter int INIT_1  = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   change_dispenser_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_EJECT  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Tube index 0..3 holds the 50, 10, 5 and 1 coins respectively.
   function automatic logic [7:0] coin_value(input logic [1:0] idx);
      logic [7:0] val;
      case (idx)
         2'd0:    val = 8'd50;
         2'd1:    val = 8'd10;
         2'd2:    val = 8'd5;
         2'd3:    val = 8'd1;
         default: val = 8'd0;
      endcase
      return val;
   endfunction

   // Refill and ejection may hit the same tube in one cycle; the result saturates.
   function automatic logic [CNT_W-1:0] tube_next(input logic [CNT_W-1:0] cnt,
                                                  input logic [CNT_W-1:0] add,
                                                  input logic             dec);
      logic [CNT_W:0]   sum;
      logic [CNT_W-1:0] res;
      sum = {1'b0, cnt} + {1'b0, add} - {{CNT_W{1'b0}}, dec};
      if (sum > {1'b0, CNT_MAX}) begin
         res = CNT_MAX;
      end else begin
         res = sum[CNT_W-1:0];
      end
      return res;
   endfunction

   state_t           state_q, state_d;
   logic [7:0]       remaining_q, remaining_d;
   logic [7:0]       short_amt_q, short_amt_d;
   logic [7:0]       eject_coin_q, eject_coin_d;
   logic [1:0]       sel_q, sel_d;
   logic             busy_q, busy_d;
   logic             eject_valid_q, eject_valid_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] tube_q [4];
   logic [CNT_W-1:0] tube_d [4];
   logic [3:0]       avail_s;
   logic             found_s;
   logic [1:0]       pick_s;
   logic             accept_s;

   // Per-tube eligibility: coin fits in the remainder and the tube is not empty.
   always_comb begin
      avail_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         avail_s[i] = (tube_q[i] != {CNT_W{1'b0}}) && (coin_value(2'(i)) <= remaining_q);
      end
   end

   // Priority pick of the largest eligible denomination.
   always_comb begin
      found_s = 1'b1;
      pick_s  = 2'd0;
      casez (avail_s)
         4'b???1: pick_s = 2'd0;
         4'b??10: pick_s = 2'd1;
         4'b?100: pick_s = 2'd2;
         4'b1000: pick_s = 2'd3;
         default: found_s = 1'b0;
      endcase
   end

   // Next-state and datapath decisions of the dispensing sequence.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      short_amt_d  = short_amt_q;
      eject_coin_d = eject_coin_q;
      sel_d        = sel_q;
      accept_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.change_req) begin
               short_amt_d = 8'd0;
               if (bus.change_amt != 8'd0) begin
                  remaining_d = bus.change_amt;
                  state_d     = ST_SELECT;
               end else begin
                  remaining_d = 8'd0;
                  state_d     = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SELECT: begin
            if (found_s) begin
               sel_d        = pick_s;
               eject_coin_d = coin_value(pick_s);
               state_d      = ST_EJECT;
            end else begin
               short_amt_d = remaining_q;
               state_d     = ST_DONE;
            end
         end
         ST_EJECT: begin
            if (bus.eject_ready) begin
               accept_s     = 1'b1;
               remaining_d  = remaining_q - eject_coin_q;
               eject_coin_d = 8'd0;
               if (remaining_d == 8'd0) begin
                  short_amt_d = 8'd0;
                  state_d     = ST_DONE;
               end else begin
                  state_d = ST_SELECT;
               end
            end else begin
               state_d = ST_EJECT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Inventory update: refill from any state, minus an accepted coin.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         tube_d[i] = tube_next(tube_q[i],
                               (bus.refill_en && (bus.refill_sel == 2'(i))) ? bus.refill_cnt
                                                                           : {CNT_W{1'b0}},
                               accept_s && (sel_q == 2'(i)));
      end
   end

   // Status flags are registered from the next state so they track state_q exactly.
   always_comb begin
      busy_d        = (state_d != ST_IDLE);
      eject_valid_d = (state_d == ST_EJECT);
      done_d        = (state_d == ST_DONE);
   end

   // State, datapath and inventory registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         remaining_q   <= 8'd0;
         short_amt_q   <= 8'd0;
         eject_coin_q  <= 8'd0;
         sel_q         <= 2'd0;
         busy_q        <= 1'b0;
         eject_valid_q <= 1'b0;
         done_q        <= 1'b0;
         tube_q[0]     <= CNT_W'(INIT_50);
         tube_q[1]     <= CNT_W'(INIT_10);
         tube_q[2]     <= CNT_W'(INIT_5);
         tube_q[3]     <= CNT_W'(INIT_1);
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         short_amt_q   <= short_amt_d;
         eject_coin_q  <= eject_coin_d;
         sel_q         <= sel_d;
         busy_q        <= busy_d;
         eject_valid_q <= eject_valid_d;
         done_q        <= done_d;
         for (int i = 0; i < 4; i++) begin
            tube_q[i] <= tube_d[i];
         end
      end
   end

   assign bus.busy        = busy_q;
   assign bus.eject_valid = eject_valid_q;
   assign bus.eject_coin  = eject_coin_q;
   assign bus.done        = done_q;
   assign bus.short_amt   = short_amt_q;
   assign bus.tube_cnt_50 = tube_q[0];
   assign bus.tube_cnt_10 = tube_q[1];
   assign bus.tube_cnt_5  = tube_q[2];
   assign bus.tube_cnt_1  = tube_q[3];

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Self-checking bench: directed scenarios plus randomized transactions scored
// against a greedy change-making model of the tube inventory.
module tb_change_dispenser_ctrl;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   change_dispenser_ctrl_if #(.CNT_W(CNT_W)) bus ();
   change_dispenser_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus.master));

   int n_cmp = 0;
   int n_bad = 0;
   int inv[4];
   int coin_val[4] = '{50, 10, 5, 1};
   int seen[$];

   function automatic int dut_cnt(input int i);
      case (i)
         0:       return int'(bus.tube_cnt_50);
         1:       return int'(bus.tube_cnt_10);
         2:       return int'(bus.tube_cnt_5);
         default: return int'(bus.tube_cnt_1);
      endcase
   endfunction

   task automatic apply_reset();
      reset = 1'b0;
      bus.change_req = 1'b0; bus.change_amt = 8'd0; bus.eject_ready = 1'b0;
      bus.refill_en = 1'b0; bus.refill_sel = 2'd0; bus.refill_cnt = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      inv = '{4, 10, 10, 20};
   endtask

   task automatic do_refill(input int sel, input int cnt);
      bus.refill_en = 1'b1; bus.refill_sel = 2'(sel); bus.refill_cnt = CNT_W'(cnt);
      @(negedge clk);
      bus.refill_en = 1'b0;
      inv[sel] = (inv[sel] + cnt > 255) ? 255 : inv[sel] + cnt;
   endtask

   // Full transaction against the greedy model; ready is asserted with ready_pct% odds.
   task automatic run_txn(input int amt, input int ready_pct, input string tag);
      int exp_q[$];
      int rem;
      int pick;
      bit fin;
      rem = amt;
      while (rem > 0) begin
         pick = -1;
         for (int i = 0; i < 4; i++)
            if (pick < 0 && inv[i] > 0 && coin_val[i] <= rem) pick = i;
         if (pick < 0) break;
         exp_q.push_back(coin_val[pick]);
         inv[pick]--;
         rem -= coin_val[pick];
      end
      seen.delete();
      bus.change_req = 1'b1; bus.change_amt = 8'(amt);
      @(negedge clk);
      bus.change_req = 1'b0; bus.change_amt = 8'($urandom);
      fin = 1'b0;
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         if (bus.done) begin
            fin = 1'b1;
            n_cmp++;
            if (bus.short_amt !== 8'(rem)) begin
               n_bad++; $display("FAIL %s short_amt: got %0d expected %0d", tag, bus.short_amt, rem);
            end
         end else if (bus.eject_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL %s extra coin: got %0d expected none", tag, bus.eject_coin);
            end else if (int'(bus.eject_coin) != exp_q[0]) begin
               n_bad++; $display("FAIL %s eject_coin: got %0d expected %0d", tag, bus.eject_coin, exp_q[0]);
            end
            bus.eject_ready = ($urandom_range(99) < ready_pct);
            if (bus.eject_ready) begin
               seen.push_back(int'(bus.eject_coin));
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
         end
         if (!fin) @(negedge clk);
      end
      bus.eject_ready = 1'b0;
      n_cmp++;
      if (!fin) begin
         n_bad++; $display("FAIL %s timeout: got no done expected done", tag);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL %s coins missing: got %0d left expected 0", tag, exp_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (dut_cnt(i) != inv[i]) begin
            n_bad++; $display("FAIL %s tube%0d: got %0d expected %0d", tag, i, dut_cnt(i), inv[i]);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_bad++; $display("FAIL %s busy after done: got %0b expected 0", tag, bus.busy);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if ({bus.busy, bus.eject_valid, bus.done} !== 3'b000 || bus.eject_coin !== 8'd0 || bus.short_amt !== 8'd0) begin
         n_bad++; $display("FAIL reset outputs: got %b/%0d/%0d expected 000/0/0",
                           {bus.busy, bus.eject_valid, bus.done}, bus.eject_coin, bus.short_amt);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (dut_cnt(i) != inv[i]) begin
            n_bad++; $display("FAIL reset tube%0d: got %0d expected %0d", i, dut_cnt(i), inv[i]);
         end
      end
   endtask

   task automatic test_greedy_37();
      int exp37[6] = '{10, 10, 10, 5, 1, 1};
      int exp_cnt[4] = '{4, 7, 9, 18};
      run_txn(37, 100, "greedy37");
      n_cmp++;
      if (seen.size() != 6) begin
         n_bad++; $display("FAIL greedy37 coin count: got %0d expected 6", seen.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (seen[i] != exp37[i]) begin
               n_bad++; $display("FAIL greedy37 coin%0d: got %0d expected %0d", i, seen[i], exp37[i]);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (dut_cnt(i) != exp_cnt[i]) begin
            n_bad++; $display("FAIL greedy37 tube%0d: got %0d expected %0d", i, dut_cnt(i), exp_cnt[i]);
         end
      end
   endtask

   task automatic test_stall();
      int hold;
      int c;
      bus.eject_ready = 1'b0;
      bus.change_req = 1'b1; bus.change_amt = 8'd50;
      @(negedge clk);
      bus.change_req = 1'b0;
      c = 0;
      while (!bus.eject_valid && c < 5) begin @(negedge clk); c++; end
      hold = 0;
      while (bus.eject_valid && hold < 20) begin
         hold++;
         n_cmp++;
         if (bus.eject_coin !== 8'd50 || int'(bus.tube_cnt_50) != inv[0]) begin
            n_bad++; $display("FAIL stall hold%0d coin/tube50: got %0d/%0d expected 50/%0d",
                              hold, bus.eject_coin, bus.tube_cnt_50, inv[0]);
         end
         bus.eject_ready = (hold >= 6);
         @(negedge clk);
      end
      bus.eject_ready = 1'b0;
      inv[0]--;
      n_cmp++;
      if (hold != 6) begin
         n_bad++; $display("FAIL stall valid cycles: got %0d expected 6", hold);
      end
      n_cmp++;
      if (bus.done !== 1'b1 || bus.short_amt !== 8'd0 || int'(bus.tube_cnt_50) != inv[0]) begin
         n_bad++; $display("FAIL stall done/short/tube50: got %0b/%0d/%0d expected 1/0/%0d",
                           bus.done, bus.short_amt, bus.tube_cnt_50, inv[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      int nvalid;
      bus.eject_ready = 1'b1;
      bus.change_req = 1'b1; bus.change_amt = 8'd60;
      @(negedge clk);
      bus.change_req = 1'b0;
      nvalid = 0;
      for (int c = 0; c < 20 && nvalid < 2; c++) begin
         if (bus.eject_valid) nvalid++;
         if (nvalid < 2) @(negedge clk);
      end
      bus.eject_ready = 1'b0;
      n_cmp++;
      if (nvalid < 2 || bus.eject_coin !== 8'd10) begin
         n_bad++; $display("FAIL areset second coin: got %0d valid coin %0d expected 2 valid coin 10",
                           nvalid, bus.eject_coin);
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({bus.busy, bus.eject_valid, bus.done} !== 3'b000 || bus.eject_coin !== 8'd0 || bus.short_amt !== 8'd0
          || bus.tube_cnt_50 !== 8'd4 || bus.tube_cnt_10 !== 8'd10 || bus.tube_cnt_5 !== 8'd10 || bus.tube_cnt_1 !== 8'd20) begin
         n_bad++; $display("FAIL areset outputs: got bvd=%b coin=%0d cnt=%0d/%0d/%0d/%0d expected 000 0 4/10/10/20",
                           {bus.busy, bus.eject_valid, bus.done}, bus.eject_coin, bus.tube_cnt_50,
                           bus.tube_cnt_10, bus.tube_cnt_5, bus.tube_cnt_1);
      end
      @(negedge clk);
      reset = 1'b1;
      inv = '{4, 10, 10, 20};
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL areset no done: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
         end
      end
   endtask

   task automatic test_depleted_10();
      for (int k = 0; k < 9; k++) run_txn(10, 100, "drain10");
      n_cmp++;
      if (bus.tube_cnt_10 !== 8'd1) begin
         n_bad++; $display("FAIL depleted tube10 pre: got %0d expected 1", bus.tube_cnt_10);
      end
      run_txn(30, 100, "depleted30");
      n_cmp++;
      if (seen.size() != 5 || seen[0] != 10 || seen[1] != 5 || seen[4] != 5) begin
         n_bad++; $display("FAIL depleted30 sequence: got %0d coins expected 10,5,5,5,5", seen.size());
      end
      n_cmp++;
      if (bus.tube_cnt_10 !== 8'd0 || bus.tube_cnt_5 !== 8'd6) begin
         n_bad++; $display("FAIL depleted30 tubes: got %0d/%0d expected 0/6", bus.tube_cnt_10, bus.tube_cnt_5);
      end
   endtask

   task automatic test_short();
      bit saw_valid;
      for (int k = 0; k < 5; k++) run_txn(4, 100, "drain1");
      n_cmp++;
      if (bus.tube_cnt_1 !== 8'd0) begin
         n_bad++; $display("FAIL short tube1 drained: got %0d expected 0", bus.tube_cnt_1);
      end
      do_refill(3, 0);
      bus.eject_ready = 1'b1;
      bus.change_req = 1'b1; bus.change_amt = 8'd3;
      @(negedge clk);
      bus.change_req = 1'b0;
      saw_valid = bus.eject_valid;
      n_cmp++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         n_bad++; $display("FAIL short cycle1: got done=%b busy=%b expected 0 1", bus.done, bus.busy);
      end
      @(negedge clk);
      saw_valid |= bus.eject_valid;
      n_cmp++;
      if (bus.done !== 1'b1 || bus.short_amt !== 8'd3 || saw_valid) begin
         n_bad++; $display("FAIL short cycle2: got done=%b short=%0d valid=%b expected 1 3 0",
                           bus.done, bus.short_amt, saw_valid);
      end
      @(negedge clk);
      bus.eject_ready = 1'b0;
      n_cmp++;
      if (bus.short_amt !== 8'd3 || bus.busy !== 1'b0) begin
         n_bad++; $display("FAIL short hold: got short=%0d busy=%b expected 3 0", bus.short_amt, bus.busy);
      end
   endtask

   task automatic test_refill();
      int c;
      bit extra;
      apply_reset();
      bus.eject_ready = 1'b1;
      bus.change_req = 1'b1; bus.change_amt = 8'd10;
      @(negedge clk);
      bus.change_req = 1'b0;
      c = 0;
      while (!bus.eject_valid && c < 5) begin @(negedge clk); c++; end
      bus.refill_en = 1'b1; bus.refill_sel = 2'd1; bus.refill_cnt = 8'd5;
      bus.change_req = 1'b1; bus.change_amt = 8'd99;
      @(negedge clk);
      bus.refill_en = 1'b0; bus.change_req = 1'b0;
      n_cmp++;
      if (bus.tube_cnt_10 !== 8'd14 || bus.done !== 1'b1) begin
         n_bad++; $display("FAIL refill+eject tube10/done: got %0d/%b expected 14/1", bus.tube_cnt_10, bus.done);
      end
      extra = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         extra |= bus.busy | bus.eject_valid;
      end
      bus.eject_ready = 1'b0;
      n_cmp++;
      if (extra) begin
         n_bad++; $display("FAIL ignored req: got busy/valid after done expected idle");
      end
      inv[1] = 14;
      do_refill(0, 255);
      n_cmp++;
      if (bus.tube_cnt_50 !== 8'd255) begin
         n_bad++; $display("FAIL refill saturate: got %0d expected 255", bus.tube_cnt_50);
      end
   endtask

   task automatic test_random();
      int amt;
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(3) == 0) do_refill($urandom_range(3), $urandom_range(40));
         amt = (t % 10 == 9) ? 0 : $urandom_range(255);
         run_txn(amt, $urandom_range(100, 30), "random");
      end
   endtask

   initial begin
      reset = 1'b0;
      bus.change_req = 1'b0; bus.change_amt = 8'd0; bus.eject_ready = 1'b0;
      bus.refill_en = 1'b0; bus.refill_sel = 2'd0; bus.refill_cnt = '0;
      test_reset();
      test_greedy_37();
      test_stall();
      test_async_reset();
      test_depleted_10();
      test_short();
      test_refill();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
